mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Memory-stage load/store unit for the RV32 five-stage pipeline. It consumes the EX/MEM pipeline-register outputs, drives a valid/ready data-bus request with byte strobes, and aligns and sign- or zero-extends load data for MEM/WB. It holds the pipeline through `M_Stall` until each access completes, and flags misaligned accesses without issuing them.

## Interface
- `DATA_WIDTH`, 32: data width; only 32 is supported.
- `ADDR_WIDTH`, 32: address width.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `M_ALUResult` in ADDR_WIDTH: effective byte address.
- `M_WriteData` in DATA_WIDTH: store data, unaligned and LSB-justified.
- `M_MemWrite` in 1: store in MEM.
- `M_ResultSrc` in 2: value 2'b01 marks a load.
- `M_Funct3` in 3: access size and sign.
- `M_ReadData` out DATA_WIDTH: extended load result to MEM/WB.
- `M_Stall` out 1: freeze PC, IF/ID, ID/EX and EX/MEM; bubble into MEM/WB.
- `M_Misaligned` out 1: misaligned access, one-cycle pulse.
- `req_valid` out 1: bus request valid.
- `req_ready` in 1: bus accepts the request.
- `req_we` out 1: 1 means write.
- `req_addr` out ADDR_WIDTH: word-aligned address, low two bits 0.
- `req_wdata` out DATA_WIDTH: lane-replicated store data.
- `req_wstrb` out 4: byte enables.
- `rsp_valid` in 1: read data valid.
- `rsp_rdata` in DATA_WIDTH: read word.

## Operation
- A memory operation is present when `M_MemWrite` is 1 or `M_ResultSrc` is 2'b01. If both are set, the store wins.
- Funct3 encodings:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Any other value is treated as a word access.
- Misaligned means a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0.
  - The op is not issued, `M_Stall`=0, `M_Misaligned`=1 for that cycle, and `M_ReadData` is 0.
- Store lanes:
  - SB: byte replicated to all lanes, `wstrb`=4'b0001<<addr[1:0].
  - SH: halfword replicated to both halves, `wstrb`=4'b0011<<{addr[1],1'b0}.
  - SW: data as is, `wstrb`=4'b1111.
  - Loads drive `wstrb`=0.
- Load extraction uses the captured `addr[1:0]` and funct3 on the captured response word.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE, with an aligned op present: capture address, lane data, strobe, we, funct3 and `addr[1:0]`; `M_Stall`=1; go to REQ.
  - IDLE, otherwise: `M_Stall`=0.
  - REQ: `req_valid`=1 with every request field stable; `M_Stall`=1.
    - On `req_valid`&`req_ready`, a store goes to DONE and a load goes to WAIT.
  - WAIT: `M_Stall`=1. On `rsp_valid`, register the extended data into `M_ReadData` and go to DONE.
  - DONE: `M_Stall`=0 and `M_ReadData` holds the result; go to IDLE unconditionally.
    - The EX/MEM register advances on this edge, so the completed op is never re-issued.
- `rsp_valid` in IDLE, REQ or DONE is ignored.
- A handshake cannot be aborted; the unit has no flush input.
- Reset mid-operation: return to IDLE immediately, drop `req_valid`, and lose any outstanding response.

## Timing
- Reset values:
  - `req_valid`, `req_we`, `req_addr`, `req_wdata`, `req_wstrb`, `M_ReadData`: 0.
  - `M_Stall` and `M_Misaligned`: forced to 0 while `rst_n` is low.
  - State: IDLE.
- `M_Stall` and `M_Misaligned` are combinational from state and the EX/MEM inputs. All bus outputs are registered.
- Store with `req_ready`=1 always: stall 2 cycles (IDLE, REQ), then DONE.
- Load with ready=1 and `rsp_valid` one cycle after the handshake: stall 3 cycles, with data in DONE.
- Each cycle of `req_ready`=0 or of response delay adds one stall cycle.
- Back-to-back memory ops: the second op is evaluated in the IDLE cycle immediately after DONE.
- A non-memory op in MEM costs zero cycles.

## Structure
- Put these in shared `pipeline_pkg`:
  - Funct3 load/store constants.
  - ResultSrc encodings (ALU 00, MEM 01, PC+4 10).
  - The LSU state enum.
- Put the combinational store-lane/strobe generator and the load extractor in sub-module `lsu_align`. The FSM stays in `mem_stage_lsu`.

## Test plan
- SB at addr 0x1003, data 0x000000A5, ready=1:
  - one REQ cycle with `req_addr`=0x1000, `wdata`=0xA5A5A5A5, `wstrb`=4'b1000, we=1;
  - stall for 2 cycles.
- LH at addr 0x2002, rdata 0x8001_1234:
  - `M_ReadData`=0xFFFF8001.
  - The same access as LHU gives 0x00008001.
- LW at 0x3000, `req_ready` low for 3 cycles, `rsp_valid` 2 cycles after the handshake:
  - `req_valid` and fields stable throughout;
  - stall for 7 cycles;
  - `M_ReadData` equals `rsp_rdata`.
- LW at 0x3002:
  - no `req_valid`;
  - `M_Misaligned`=1 for one cycle;
  - `M_Stall`=0.
- Back-to-back SW then LB:
  - two distinct requests and no duplicate issue;
  - a spurious `rsp_valid` during the SW's REQ is ignored.
- `rst_n` low during WAIT:
  - all outputs are 0 next cycle and state is IDLE;
  - a late `rsp_valid` after reset is ignored.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared RV32 pipeline constants: funct3 access encodings, ResultSrc encodings
// and the memory-stage LSU state type.
package pipeline_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } access_size_e;

    // Unlisted funct3 values fall back to a word access.
    function automatic access_size_e decode_size(input logic [2:0] funct3, input logic store);
        access_size_e size;
        size = SZ_WORD;
        if (store) begin
            if (funct3 == F3_SB)      size = SZ_BYTE;
            else if (funct3 == F3_SH) size = SZ_HALF;
        end else begin
            if (funct3 == F3_LB || funct3 == F3_LBU)      size = SZ_BYTE;
            else if (funct3 == F3_LH || funct3 == F3_LHU) size = SZ_HALF;
        end
        return size;
    endfunction

    function automatic logic is_misaligned(input access_size_e size, input logic [1:0] offset);
        return (size == SZ_HALF && offset[0]) || (size == SZ_WORD && offset != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational store lane replication / byte-strobe generation and
// load byte/halfword extraction with sign or zero extension.
module lsu_align
    import pipeline_pkg::*;
(
    input  logic [1:0]  st_offset,
    input  logic [2:0]  st_funct3,
    input  logic        st_store,
    input  logic [31:0] st_data,
    output logic [31:0] st_lane_data,
    output logic [3:0]  st_strb,
    input  logic [1:0]  ld_offset,
    input  logic [2:0]  ld_funct3,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    access_size_e st_size;
    access_size_e ld_size;
    logic [7:0]   ld_byte;
    logic [15:0]  ld_half;

    always_comb begin
        st_size      = decode_size(st_funct3, 1'b1);
        st_lane_data = st_data;
        st_strb      = 4'b1111;
        case (st_size)
            SZ_BYTE: begin
                st_lane_data = {4{st_data[7:0]}};
                st_strb      = 4'b0001 << st_offset;
            end
            SZ_HALF: begin
                st_lane_data = {2{st_data[15:0]}};
                st_strb      = 4'b0011 << {st_offset[1], 1'b0};
            end
            default: ;
        endcase
        if (!st_store) st_strb = '0;
    end

    // funct3[2] set selects the unsigned (LBU/LHU) variants.
    always_comb begin
        ld_size = decode_size(ld_funct3, 1'b0);
        ld_byte = ld_word[{ld_offset, 3'b000} +: 8];
        ld_half = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_byte[7] & ~ld_funct3[2]}}, ld_byte};
            SZ_HALF: ld_data = {{16{ld_half[15] & ~ld_funct3[2]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one valid/ready bus request per aligned
// access, stalls the pipeline until completion and returns extended load data.
module mem_stage_lsu
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] M_ALUResult,
    input  logic [DATA_WIDTH-1:0] M_WriteData,
    input  logic                  M_MemWrite,
    input  logic [1:0]            M_ResultSrc,
    input  logic [2:0]            M_Funct3,
    output logic [DATA_WIDTH-1:0] M_ReadData,
    output logic                  M_Stall,
    output logic                  M_Misaligned,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_we,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_wdata,
    output logic [3:0]            req_wstrb,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_rdata
);

    lsu_state_e            state;
    lsu_state_e            next_state;
    logic                  mem_op;
    logic                  misaligned;
    logic                  start;
    logic [2:0]            funct3_q;
    logic [1:0]            offset_q;
    logic [DATA_WIDTH-1:0] lane_data;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [3:0]            strb;

    // A store takes priority when both store and load are flagged.
    assign mem_op     = M_MemWrite || (M_ResultSrc == RES_MEM);
    assign misaligned = mem_op && is_misaligned(decode_size(M_Funct3, M_MemWrite), M_ALUResult[1:0]);
    assign M_ReadData = M_Misaligned ? '0 : rdata_q;

    lsu_align u_align (
        .st_offset    (M_ALUResult[1:0]),
        .st_funct3    (M_Funct3),
        .st_store     (M_MemWrite),
        .st_data      (M_WriteData),
        .st_lane_data (lane_data),
        .st_strb      (strb),
        .ld_offset    (offset_q),
        .ld_funct3    (funct3_q),
        .ld_word      (rsp_rdata),
        .ld_data      (load_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LSU_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state   = state;
        M_Stall      = 1'b0;
        M_Misaligned = 1'b0;
        start        = 1'b0;
        case (state)
            LSU_IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        M_Misaligned = 1'b1;
                    end else begin
                        start      = 1'b1;
                        M_Stall    = 1'b1;
                        next_state = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                M_Stall = 1'b1;
                if (req_valid && req_ready) next_state = req_we ? LSU_DONE : LSU_WAIT;
            end
            LSU_WAIT: begin
                M_Stall = 1'b1;
                if (rsp_valid) next_state = LSU_DONE;
            end
            LSU_DONE: next_state = LSU_IDLE;
            default:  next_state = LSU_IDLE;
        endcase
        if (!rst_n) begin
            M_Stall      = 1'b0;
            M_Misaligned = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
            funct3_q  <= '0;
            offset_q  <= '0;
            rdata_q   <= '0;
        end else begin
            if (start) begin
                req_valid <= 1'b1;
                req_we    <= M_MemWrite;
                req_addr  <= {M_ALUResult[ADDR_WIDTH-1:2], 2'b00};
                req_wdata <= lane_data;
                req_wstrb <= strb;
                funct3_q  <= M_Funct3;
                offset_q  <= M_ALUResult[1:0];
            end else if (state == LSU_REQ && req_ready) begin
                req_valid <= 1'b0;
            end
            if (state == LSU_WAIT && rsp_valid) rdata_q <= load_ext;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized
// accesses against a timeline/memory reference model.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] M_ALUResult, M_WriteData, M_ReadData;
    logic        M_MemWrite, M_Stall, M_Misaligned;
    logic [1:0]  M_ResultSrc;
    logic [2:0]  M_Funct3;
    logic        req_valid, req_ready, req_we, rsp_valid;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_wstrb;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mem [16];
    bit          force_spurious = 0;

    int          last_stalls, last_reqs;
    logic [31:0] last_addr, last_wdata, last_rd;
    logic [3:0]  last_strb;
    logic        last_we;

    always #5 clk = ~clk;

    mem_stage_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .M_ALUResult  (M_ALUResult),
        .M_WriteData  (M_WriteData),
        .M_MemWrite   (M_MemWrite),
        .M_ResultSrc  (M_ResultSrc),
        .M_Funct3     (M_Funct3),
        .M_ReadData   (M_ReadData),
        .M_Stall      (M_Stall),
        .M_Misaligned (M_Misaligned),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] f3, input logic store);
        if (store) return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        return (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n = size_bytes(f3, 1'b1);
        if (n == 1) return {24'b0, d[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'b0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [1:0] off);
        int n = size_bytes(f3, 1'b1);
        if (n == 1) return 4'(1 << off);
        if (n == 2) return 4'(3 << (off & 2'b10));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        int n = size_bytes(f3, 1'b0);
        logic [31:0] v = w >> (8 * off);
        if (n == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (n == 2) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, M_Stall, 0);
        chk({tag, "_mis"}, M_Misaligned, 0);
        chk({tag, "_valid"}, req_valid, 0);
        chk({tag, "_we"}, req_we, 0);
        chk({tag, "_addr"}, req_addr, 0);
        chk({tag, "_wdata"}, req_wdata, 0);
        chk({tag, "_wstrb"}, req_wstrb, 0);
        chk({tag, "_rdata"}, M_ReadData, 0);
    endtask

    task automatic idle_cycle();
        int k;
        @(negedge clk);
        k = $urandom_range(0, 2);
        M_MemWrite  = 1'b0;
        M_ResultSrc = (k == 0) ? 2'b00 : (k == 1) ? 2'b10 : 2'b11;
        M_ALUResult = $urandom;
        M_Funct3    = 3'($urandom_range(0, 7));
        req_ready   = 1'($urandom_range(0, 1));
        rsp_valid   = 1'($urandom_range(0, 1));
        rsp_rdata   = $urandom;
        #1;
        chk("idle_stall", M_Stall, 0);
        chk("idle_mis", M_Misaligned, 0);
        chk("idle_valid", req_valid, 0);
    endtask

    // Timeline model: op seen in cycle 0, request visible in cycles 1..1+nr,
    // load response driven nd cycles after the handshake, completion at cycle total.
    task automatic run_op(input logic [31:0] addr, input logic [31:0] data, input logic store,
                          input logic [2:0] f3, input int nr, input int nd);
        logic [1:0]  off;
        bit          mis, in_req;
        int          n, total, idx;
        logic [31:0] ea, ew, erd;
        logic [3:0]  es;
        off   = addr[1:0];
        n     = size_bytes(f3, store);
        mis   = (n == 2 && off[0]) || (n == 4 && off != 2'b00);
        ea    = {addr[31:2], 2'b00};
        ew    = model_wdata(f3, data);
        es    = store ? model_strb(f3, off) : 4'h0;
        idx   = int'(addr[5:2]);
        erd   = model_load(f3, off, mem[idx]);
        total = mis ? 0 : (store ? 2 + nr : 2 + nr + nd);
        last_stalls = 0;
        last_reqs   = 0;
        for (int c = 0; c <= total; c++) begin
            @(negedge clk);
            M_ALUResult = addr;
            M_WriteData = data;
            M_MemWrite  = store;
            M_ResultSrc = store ? 2'($urandom_range(0, 3)) : 2'b01;
            M_Funct3    = f3;
            in_req      = !mis && c >= 1 && c <= 1 + nr;
            req_ready   = (c >= 1 && c <= nr) ? 1'b0 : (c == 1 + nr) ? 1'b1 : 1'($urandom_range(0, 1));
            if (!store && !mis && c > 1 + nr && c < 1 + nr + nd) begin
                rsp_valid = 1'b0;
                rsp_rdata = $urandom;
            end else if (!store && !mis && c == 1 + nr + nd) begin
                rsp_valid = 1'b1;
                rsp_rdata = mem[idx];
            end else begin
                rsp_valid = force_spurious ? 1'b1 : 1'($urandom_range(0, 1));
                rsp_rdata = $urandom;
            end
            #1;
            chk("stall", M_Stall, c < total);
            chk("misaligned", M_Misaligned, mis && c == 0);
            chk("req_valid", req_valid, in_req);
            if (in_req) begin
                chk("req_addr", req_addr, ea);
                chk("req_we", req_we, store);
                chk("req_wstrb", req_wstrb, es);
                if (store) chk("req_wdata", req_wdata, ew);
                last_addr  = req_addr;
                last_wdata = req_wdata;
                last_strb  = req_wstrb;
                last_we    = req_we;
            end
            if (req_valid && req_ready) last_reqs++;
            if (M_Stall) last_stalls++;
            if (c == total) begin
                if (mis)         chk("rdata_misaligned", M_ReadData, 0);
                else if (!store) chk("load_data", M_ReadData, erd);
                last_rd = M_ReadData;
            end
        end
        chk("handshakes", last_reqs, mis ? 0 : 1);
        if (store && !mis)
            for (int b = 0; b < 4; b++)
                if (es[b]) mem[idx][8*b +: 8] = ew[8*b +: 8];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        logic        st;
        int          n;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        // Reset with an aligned load presented: stall/misaligned forced low.
        rst_n = 1'b0;
        M_ALUResult = 32'h100; M_WriteData = '0; M_MemWrite = 1'b0;
        M_ResultSrc = 2'b01; M_Funct3 = 3'b010;
        req_ready = 1'b1; rsp_valid = 1'b0; rsp_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        M_ResultSrc = 2'b00;
        rst_n = 1'b1;

        run_op(32'h0000_1003, 32'h0000_00A5, 1'b1, 3'b000, 0, 1);
        chk("sb_addr", last_addr, 32'h0000_1000);
        chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);
        chk("sb_strb", last_strb, 4'b1000);
        chk("sb_we", last_we, 1);
        chk("sb_stalls", last_stalls, 2);

        mem[0] = 32'h8001_1234;
        run_op(32'h0000_2002, $urandom, 1'b0, 3'b001, 0, 1);
        chk("lh_result", last_rd, 32'hFFFF_8001);
        chk("lh_stalls", last_stalls, 3);
        run_op(32'h0000_2002, $urandom, 1'b0, 3'b101, 0, 1);
        chk("lhu_result", last_rd, 32'h0000_8001);

        mem[0] = 32'hDEAD_BEEF;
        run_op(32'h0000_3000, $urandom, 1'b0, 3'b010, 3, 2);
        chk("lw_slow_result", last_rd, 32'hDEAD_BEEF);
        chk("lw_slow_stalls", last_stalls, 7);

        run_op(32'h0000_3002, $urandom, 1'b0, 3'b010, 0, 1);
        chk("lw_mis_stalls", last_stalls, 0);
        idle_cycle();

        force_spurious = 1;
        run_op(32'h0000_0040, 32'h8899_AABB, 1'b1, 3'b010, 0, 1);
        force_spurious = 0;
        run_op(32'h0000_0043, $urandom, 1'b0, 3'b000, 0, 1);
        chk("sw_lb_result", last_rd, 32'hFFFF_FF88);

        // Reset while a load waits for its response.
        @(negedge clk);
        M_ALUResult = 32'h0000_3000; M_MemWrite = 1'b0; M_ResultSrc = 2'b01; M_Funct3 = 3'b010;
        req_ready = 1'b0; rsp_valid = 1'b0;
        #1;
        chk("rstw_idle_stall", M_Stall, 1);
        @(negedge clk);
        req_ready = 1'b1;
        #1;
        chk("rstw_req_valid", req_valid, 1);
        @(negedge clk);
        req_ready = 1'b0;
        #1;
        chk("rstw_wait_valid", req_valid, 0);
        chk("rstw_wait_stall", M_Stall, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_in_wait");
        @(negedge clk);
        rst_n = 1'b1;
        M_ResultSrc = 2'b00;
        rsp_valid = 1'b1;
        rsp_rdata = 32'h1234_5678;
        #1;
        chk("late_rsp_stall", M_Stall, 0);
        chk("late_rsp_valid", req_valid, 0);
        @(negedge clk);
        rsp_valid = 1'b0;
        #1;
        chk("late_rsp_rdata", M_ReadData, 0);
        chk("late_rsp_valid2", req_valid, 0);

        for (int i = 0; i < 300; i++) begin
            a  = $urandom;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            n  = size_bytes(f3, st);
            if ($urandom_range(0, 3) != 0) begin
                if (n == 4)      a[1:0] = 2'b00;
                else if (n == 2) a[0]   = 1'b0;
            end
            run_op(a, $urandom, st, f3, $urandom_range(0, 3), $urandom_range(1, 4));
            if ($urandom_range(0, 4) == 0) idle_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
